// File: rtl/mix_pkg.sv
// mix_pkg: shared types and constants for the PCM mix sequencer.
//   state_e    : sequencer state encoding (IDLE, GATHER, DIVIDE, OUTPUT)
//   MIX_DATA_W : default sample width
//   NUM_CH     : number of mixed channels
//   ACC_W      : accumulator width (sum of four samples never overflows)
//   CNT_W      : active-channel count width (0..4)
//   DIV_CYCLES : iterations of the sequential divider
//   CH_*       : channel index of each wave generator
package mix_pkg;

  localparam int MIX_DATA_W = 18;
  localparam int NUM_CH     = 4;
  localparam int ACC_W      = MIX_DATA_W + 2;
  localparam int CNT_W      = 3;
  localparam int DIV_CYCLES = 20;

  localparam int CH_SQ = 0;
  localparam int CH_ST = 1;
  localparam int CH_SN = 2;
  localparam int CH_C  = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    DIVIDE = 2'd2,
    OUTPUT = 2'd3
  } state_e;

endpackage

// File: rtl/mix_divider.sv
// mix_divider: restoring divider, one quotient bit per cycle.
//   BIT_CLK      : clock
//   RESET_N      : synchronous active-low reset
//   start_i      : load dividend/divisor and begin (sampled on a clock edge)
//   dividend_i   : ACC_W-bit unsigned dividend
//   divisor_i    : CNT_W-bit unsigned divisor (0 gives a quotient of 0)
//   quotient_o   : low OUT_W bits of floor(dividend / divisor)
//   done_o       : high for one cycle, DIV_CYCLES edges after the start edge
module mix_divider
  import mix_pkg::*;
#(
  parameter int OUT_W = MIX_DATA_W
) (
  input  logic             BIT_CLK,
  input  logic             RESET_N,
  input  logic             start_i,
  input  logic [ACC_W-1:0] dividend_i,
  input  logic [CNT_W-1:0] divisor_i,
  output logic [OUT_W-1:0] quotient_o,
  output logic             done_o
);

  logic [ACC_W-1:0] quo_q;
  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] den_q;
  logic [4:0]       step_q;
  logic [CNT_W:0]   shifted;
  logic             fits;

  // Remainder is always below the divisor (<= 4), so CNT_W bits suffice.
  assign shifted = {rem_q, quo_q[ACC_W-1]};
  assign fits    = shifted >= {1'b0, den_q};

  always_ff @(posedge BIT_CLK) begin
    if (!RESET_N) begin
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      step_q <= '0;
      done_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (start_i) begin
        quo_q  <= dividend_i;
        rem_q  <= '0;
        den_q  <= divisor_i;
        step_q <= 5'(DIV_CYCLES);
      end else if (step_q != 5'd0) begin
        quo_q  <= {quo_q[ACC_W-2:0], fits};
        rem_q  <= fits ? CNT_W'(shifted - {1'b0, den_q}) : shifted[CNT_W-1:0];
        step_q <= step_q - 5'd1;
        done_o <= (step_q == 5'd1);
      end
    end
  end

  // A zero divisor makes every trial subtraction succeed; mask that out.
  assign quotient_o = (den_q == '0) ? '0 : quo_q[OUT_W-1:0];

endmodule

// File: rtl/pcm_mix_sequencer.sv
// pcm_mix_sequencer: once per AC97 frame, averages the enabled wave
// generator samples through one shared accumulator and divider and
// presents a registered PCM sample.
//   BIT_CLK, RESET_N          : clock, synchronous active-low reset
//   frame_sig                 : frame marker, rising edge starts a mix
//   SW[3:0]                   : channel enables (square, saw, sine, custom)
//   SQ/ST/SN/C_WAVE           : unsigned DATA_W-bit samples
//   PCM_LR, PCM_VALID         : mixed sample and its one-cycle update strobe
//   BUSY, OVERRUN             : mix in progress / frame edge seen while busy
// Optional build macro MIX_SLEW_EN: limit each update to SLEW_STEP.
//
// state  | meaning
// IDLE   | waiting for a frame_sig rising edge
// GATHER | 4 cycles, visiting channel idx_q and summing enabled samples
// DIVIDE | 20 cycles while the divider forms sum / count
// OUTPUT | load PCM_LR, pulse PCM_VALID, return to IDLE
module pcm_mix_sequencer
  import mix_pkg::*;
#(
  parameter int DATA_W    = MIX_DATA_W,
  parameter int SLEW_STEP = 1024
) (
  input  logic              BIT_CLK,
  input  logic              RESET_N,
  input  logic              frame_sig,
  input  logic [3:0]        SW,
  input  logic [DATA_W-1:0] SQ_WAVE,
  input  logic [DATA_W-1:0] ST_WAVE,
  input  logic [DATA_W-1:0] SN_WAVE,
  input  logic [DATA_W-1:0] C_WAVE,
  output logic [DATA_W-1:0] PCM_LR,
  output logic              PCM_VALID,
  output logic              BUSY,
  output logic              OVERRUN
);

  state_e             state_q;
  logic               frame_q;
  logic [NUM_CH-1:0]  mask_q;
  logic [1:0]         idx_q;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         dcnt_q;
  logic [DATA_W-1:0]  wave_sel;
  logic [DATA_W-1:0]  quot;
  logic [DATA_W-1:0]  pcm_d;
  logic               frame_edge;
  logic               take;
  logic               div_start;
  logic               div_done;

  assign frame_edge = frame_sig & ~frame_q;
  assign take       = mask_q[idx_q];

  always_comb begin
    wave_sel = '0;
    case (idx_q)
      2'(CH_SQ): wave_sel = SQ_WAVE;
      2'(CH_ST): wave_sel = ST_WAVE;
      2'(CH_SN): wave_sel = SN_WAVE;
      default:   wave_sel = C_WAVE;
    endcase
  end

  assign acc_d = acc_q + (take ? ACC_W'(wave_sel) : '0);
  assign cnt_d = cnt_q + CNT_W'(take);

  // Divider is launched on the last GATHER edge with the final sum, so its
  // 20 iterations land exactly on the DIVIDE edges.
  assign div_start = (state_q == GATHER) && (idx_q == 2'd3);

  mix_divider #(.OUT_W(DATA_W)) u_div (
    .BIT_CLK    (BIT_CLK),
    .RESET_N    (RESET_N),
    .start_i    (div_start),
    .dividend_i (acc_d),
    .divisor_i  (cnt_d),
    .quotient_o (quot),
    .done_o     (div_done)
  );

`ifdef MIX_SLEW_EN
  localparam logic [DATA_W:0] STEP = (DATA_W+1)'(SLEW_STEP);
  logic [DATA_W:0] up_lim;
  always_comb begin
    up_lim = {1'b0, PCM_LR} + STEP;
    if ({1'b0, quot} > up_lim)
      pcm_d = up_lim[DATA_W-1:0];
    else if ({1'b0, PCM_LR} > ({1'b0, quot} + STEP))
      pcm_d = PCM_LR - STEP[DATA_W-1:0];
    else
      pcm_d = quot;
  end
`else
  assign pcm_d = quot;
`endif

  always_ff @(posedge BIT_CLK) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      frame_q   <= 1'b0;
      mask_q    <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      dcnt_q    <= '0;
      PCM_LR    <= '0;
      PCM_VALID <= 1'b0;
      BUSY      <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      frame_q   <= frame_sig;
      PCM_VALID <= 1'b0;
      OVERRUN   <= frame_edge && (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (frame_edge) begin
            mask_q  <= SW;
            acc_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            BUSY    <= 1'b1;
            state_q <= GATHER;
          end
        end
        GATHER: begin
          acc_q <= acc_d;
          cnt_q <= cnt_d;
          idx_q <= idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            dcnt_q  <= 5'(DIV_CYCLES - 1);
            state_q <= DIVIDE;
          end
        end
        DIVIDE: begin
          if (dcnt_q == 5'd0) state_q <= OUTPUT;
          else                dcnt_q  <= dcnt_q - 5'd1;
        end
        OUTPUT: begin
          if (div_done) begin
            PCM_LR    <= pcm_d;
            PCM_VALID <= 1'b1;
            BUSY      <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pcm_mix_sequencer.sv
module tb_pcm_mix_sequencer;

  localparam int DW   = 18;
  localparam int STEP = 1024;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          frame_sig;
  logic [3:0]    sw;
  logic [DW-1:0] sq, st, sn, cw;
  logic [DW-1:0] pcm;
  logic          valid, busy, overrun;

  int total = 0;
  int bad   = 0;
  int pcm_model = 0;

  always #5 clk = ~clk;

  pcm_mix_sequencer #(.DATA_W(DW), .SLEW_STEP(STEP)) dut (
    .BIT_CLK   (clk),
    .RESET_N   (rst_n),
    .frame_sig (frame_sig),
    .SW        (sw),
    .SQ_WAVE   (sq),
    .ST_WAVE   (st),
    .SN_WAVE   (sn),
    .C_WAVE    (cw),
    .PCM_LR    (pcm),
    .PCM_VALID (valid),
    .BUSY      (busy),
    .OVERRUN   (overrun)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Average of enabled channels, then optional per-frame slew toward it.
  function automatic int mix_ref(input logic [3:0] m, input int a, input int b,
                                 input int c, input int d, input int prev);
    int vals[4];
    int sum, n, q, r;
    vals[0] = a; vals[1] = b; vals[2] = c; vals[3] = d;
    sum = 0; n = 0;
    for (int i = 0; i < 4; i++) if (m[i]) begin sum += vals[i]; n++; end
    q = (n == 0) ? 0 : sum / n;
    r = q;
`ifdef MIX_SLEW_EN
    if (q - prev > STEP)      r = prev + STEP;
    else if (prev - q > STEP) r = prev - STEP;
`endif
    return r;
  endfunction

  task automatic run_frame(input string tag, input logic [3:0] m, input int a, input int b,
                           input int c, input int d, input int ovr_at, input int sw_flip_at);
    int exp, nvalid, novr, ovr_edge;
    sw = m; sq = DW'(a); st = DW'(b); sn = DW'(c); cw = DW'(d);
    exp = mix_ref(m, a, b, c, d, pcm_model);
    frame_sig = 1'b1;
    tick();                                   // edge k
    check_val({tag, "_busy_start"}, 32'(busy), 32'd1);
    frame_sig = 1'b0;
    nvalid = 0; novr = 0; ovr_edge = 0;
    for (int e = 1; e <= 24; e++) begin
      if (e == ovr_at)     frame_sig = 1'b1;
      if (e == ovr_at + 1) frame_sig = 1'b0;
      if (e == sw_flip_at) sw = ~m;
      tick();
      if (valid)   nvalid++;
      if (overrun) begin novr++; ovr_edge = e; end
    end
    check_val({tag, "_early_valid"}, 32'(nvalid), 32'd0);
    check_val({tag, "_busy_k24"}, 32'(busy), 32'd1);
    tick();                                   // edge k+25
    if (overrun) novr++;
    check_val({tag, "_valid_k25"}, 32'(valid), 32'd1);
    check_val({tag, "_pcm"}, 32'(pcm), 32'(exp));
    check_val({tag, "_busy_end"}, 32'(busy), 32'd0);
    pcm_model = exp;
    tick();
    check_val({tag, "_valid_k26"}, 32'(valid), 32'd0);
    check_val({tag, "_ovr_count"}, 32'(novr), (ovr_at > 0) ? 32'd1 : 32'd0);
    check_val({tag, "_ovr_edge"}, 32'(ovr_edge), 32'(ovr_at));
    sw = m;
    repeat (3) tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    rst_n = 1'b0; frame_sig = 1'b0; sw = '0; sq = '0; st = '0; sn = '0; cw = '0;
    repeat (3) tick();
    check_val("rst_pcm", 32'(pcm), 32'd0);
    check_val("rst_valid", 32'(valid), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_ovr", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    run_frame("sq_only", 4'b0001, 131072, 7, 9, 11, 0, 0);
    run_frame("three_ch", 4'b0111, 100, 200, 301, 999, 0, 0);
    run_frame("none", 4'b0000, 5000, 5000, 5000, 5000, 0, 0);
    run_frame("overrun", 4'b0011, 1000, 3000, 77, 88, 10, 3);
    run_frame("ones", 4'b1101, 1, 50, 1, 1, 0, 0);

    // Reset in the middle of a mix.
    sw = 4'b0001; sq = 18'd40000;
    frame_sig = 1'b1;
    tick();
    frame_sig = 1'b0;
    repeat (11) tick();                       // through edge k+11
    rst_n = 1'b0;
    tick();                                   // edge k+12
    check_val("midrst_valid", 32'(valid), 32'd0);
    check_val("midrst_pcm", 32'(pcm), 32'd0);
    check_val("midrst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    pcm_model = 0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin tick(); if (valid) nv++; end
    check_val("midrst_no_valid", 32'(nv), 32'd0);
    run_frame("after_rst", 4'b1010, 11, 222, 33, 444, 0, 0);

`ifdef MIX_SLEW_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    pcm_model = 0;
    for (int f = 0; f < 5; f++) begin
      run_frame("slew", 4'b0001, 5000, 0, 0, 0, 0, 0);
      check_val("slew_const", 32'(pcm), (f < 4) ? 32'(1024 * (f + 1)) : 32'd5000);
    end
`endif

    for (int f = 0; f < 40; f++) begin
      run_frame("rand", 4'($urandom_range(0, 15)),
                int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                int'($urandom_range(0, 262143)), int'($urandom_range(0, 262143)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 20)) : 0,
                int'($urandom_range(1, 20)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pcm_mix_sequencer.md
# pcm_mix_sequencer

Frame-scheduled mixer that time-shares one accumulator and one sequential divider across the four waveform generators (square, sawtooth, sine, custom). Once per AC97 frame it snapshots the switch mask, accumulates the enabled samples and divides by the active count. It then presents one registered PCM sample to the codec serializer. It sits between the wave generators and the AC97 output path.

## Interface
- DATA_W, 18: sample width of each wave input and of PCM_LR.
- SLEW_STEP, 1024: maximum per-frame change of PCM_LR; used only with MIX_SLEW_EN.
- BIT_CLK  in  1  codec bit clock; the only clock.
- RESET_N  in  1  synchronous, active-low reset.
- frame_sig  in  1  frame marker from the AC97 link; a rising edge starts a mix.
- SW  in  4  channel enables: [0] square, [1] sawtooth, [2] sine, [3] custom.
- SQ_WAVE, ST_WAVE, SN_WAVE, C_WAVE  in  DATA_W each  unsigned samples.
- PCM_LR  out  DATA_W  mixed sample; held between updates.
- PCM_VALID  out  1  one-cycle pulse when PCM_LR updates.
- BUSY  out  1  high while a mix is in progress.
- OVERRUN  out  1  one-cycle pulse when a frame edge arrives while BUSY.

## Operation
- Start condition: frame_sig is high at a BIT_CLK edge, the registered previous sample is low, and state is IDLE.
- On start:
  - Latch SW into mask_q.
  - Clear the 20-bit accumulator.
  - Clear the active count.
  - Enter GATHER.
- States: IDLE → GATHER → DIVIDE → OUTPUT → IDLE.
- GATHER (4 cycles):
  - The channel index i runs 0..3.
  - If mask_q[i] is set, add wave i, zero-extended to 20 bits, to the accumulator and increment the count.
  - Wave inputs are sampled in the cycle their channel is visited. Generators hold samples for the whole frame.
- DIVIDE (20 cycles):
  - The divider computes floor(acc / count).
  - If count is 0, the divider still runs and its result is forced to 0, so there is no divide-by-zero.
  - The quotient is at most 2^18−1; the low DATA_W bits are taken.
- OUTPUT (1 cycle): load PCM_LR from the quotient (or the slewed value) and pulse PCM_VALID.
- The sum is divided once per frame, not per channel. Example: (1+1+1)/3 = 1.
- SW changes after the start edge have no effect until the next frame.
- A frame edge while BUSY is ignored and pulses OVERRUN. The mix in progress completes normally.
- Reset:
  - PCM_LR=0, PCM_VALID=0, BUSY=0, OVERRUN=0.
  - State IDLE, frame_sig history=0, accumulator and count 0.
- Reset mid-mix aborts the mix: no PCM_VALID, and PCM_LR=0.

## Timing
- Edge k is the start edge.
- GATHER occupies edges k+1..k+4.
- DIVIDE occupies edges k+5..k+24.
- PCM_LR is updated at edge k+25, with PCM_VALID high for the following cycle. Latency is a fixed 25 cycles, independent of mask.
- BUSY is high from after edge k until after edge k+25.
- The earliest next start is edge k+26. Frame period (256 BIT_CLK) far exceeds this.

## Configuration
- MIX_SLEW_EN defined:
  - In OUTPUT, if |q − PCM_LR| > SLEW_STEP, PCM_LR moves SLEW_STEP toward q.
  - Otherwise PCM_LR = q.
  - This limits clicks on switch changes.
- MIX_SLEW_EN undefined: PCM_LR = q directly, and SLEW_STEP is unused.

## Structure
- Package mix_pkg holds:
  - the state enum (IDLE, GATHER, DIVIDE, OUTPUT);
  - NUM_CH=4, ACC_W=DATA_W+2, DIV_CYCLES=20;
  - channel index constants CH_SQ=0, CH_ST=1, CH_SN=2, CH_C=3.
- Sub-module mix_divider: sequential restoring divider.
  - Inputs: 20-bit dividend, 3-bit divisor, start.
  - Outputs: quotient, and done asserted exactly DIV_CYCLES after start.
  - Also reset by RESET_N.

## Test plan
- SW=0001, SQ_WAVE=131072, frame edge at k → PCM_LR=131072 and PCM_VALID at k+25; BUSY low after.
- SW=0111, SQ=100, ST=200, SN=301, C=999 → PCM_LR=200 (601/3); C ignored.
- SW=0000, all waves 5000 → PCM_LR=0, PCM_VALID still pulses at k+25.
- Second frame edge at k+10 → OVERRUN pulse at k+10, exactly one PCM_VALID; SW toggled at k+3 does not alter the result.
- RESET_N low at k+12 → no PCM_VALID, PCM_LR=0, BUSY=0; the next frame mixes correctly.
- MIX_SLEW_EN, SLEW_STEP=1024, SW=0001, SQ=5000 from PCM_LR=0 → successive frames give 1024, 2048, 3072, 4096, 5000.
